nios_system_char_serializer: RTL
================================

# nios_system_char_serializer

Downstream stage of the `char_complete_tx` PIO: it watches that one-bit "character ready" flag from the Nios II. On each rising edge it latches the 8-bit character on `char_data` and shifts it out as a framed asynchronous serial word on `serial_out`. `busy` and `tx_done` are read back by software through input PIOs, which closes the handshake.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range ≥ 2.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `char_complete_tx`  in  1: level from the `char_complete_tx` PIO `out_port`; a 0→1 transition requests transmission.
- `char_data`  in  8: character to send; sampled only on the accepted request edge.
- `serial_out`  out  1: serial line; idles high.
- `busy`  out  1: high while a frame is in progress.
- `tx_done`  out  1: one-cycle pulse when a frame's stop bit completes.
- `overrun`  out  1: sticky flag; set when a request edge arrives while `busy`.

## Operation
- Edge detect:
  - `prev` register samples `char_complete_tx` every cycle.
  - `rise = char_complete_tx & ~prev`.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `serial_out = 1`, `busy = 0`.
  - On `rise`: load `shift <= char_data`, clear `overrun`, go to START.
- START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx = 0`.
- DATA:
  - Drive `shift[0]` (LSB first) for `CLKS_PER_BIT` cycles, then shift right and increment `bit_idx`.
  - After bit 7, go to PARITY (macro defined) or STOP.
- STOP: drive 1 for `CLKS_PER_BIT` cycles, then go to IDLE and pulse `tx_done`.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT-1`, clears on every state or bit transition; no free-running wrap across states.
- `rise` while not IDLE:
  - Request is dropped; the frame in flight is unaffected.
  - `overrun <= 1`, held until the next accepted request.
- `rise` in the same cycle the FSM returns to IDLE: dropped and counted as overrun; `busy` is still high in that cycle.
- `char_data` changes during a frame have no effect.
- Reset (at any point, including mid-frame), on the next clock edge:
  - State IDLE.
  - `serial_out = 1`, `busy = 0`, `tx_done = 0`, `overrun = 0`.
  - `prev = 0`, counters 0, `shift = 0`.

## Timing
- All outputs are registered.
- Request edge: `char_complete_tx` is high at edge N and `prev` is 0. At edge N+1, `serial_out` is 0 and `busy` is 1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length:
  - 10 × `CLKS_PER_BIT` cycles without the macro.
  - 11 × `CLKS_PER_BIT` cycles with it.
- At the edge that ends STOP: `busy` goes 0 and `tx_done` goes 1 for one cycle.
- Earliest accepted next request: the cycle after `busy` is observed at 0.
- Minimum idle between frames is one cycle.
- Software must drop `char_complete_tx` to 0 and raise it again to request the next character; a held level never retriggers.

## Configuration
- `CHAR_SERIALIZER_PARITY_EN`.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 latched data bits) for `CLKS_PER_BIT` cycles.
  - Frame is 11 bits.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame is 10 bits.

## Test plan
- Basic frame (`CLKS_PER_BIT=4`, no parity): `char_data=0xA5`, raise `char_complete_tx` → `serial_out` sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles each. `busy` is high for 40 cycles, then `tx_done` pulses once.
- Held level: keep `char_complete_tx=1` for 100 cycles after one frame → exactly one frame sent; `overrun` stays 0.
- Overrun: second 0→1 edge at cycle 12 of a frame carrying `0x3C` → frame still sends `0x3C` unchanged and `overrun=1`. The next accepted request clears `overrun`.
- Reset mid-frame: assert `reset_n=0` during DATA bit 3 → after the next edge, `serial_out=1`, `busy=0`, `tx_done=0`. A subsequent request for `0x81` sends a clean frame.
- Parity (macro defined, `CLKS_PER_BIT=4`): `0x07` → parity bit 1, `0x03` → parity bit 0. Frame is 44 cycles, with `tx_done` one cycle after the stop bit completes.
- Back-to-back: request `0x55`, wait for `tx_done`, re-request `0xAA` on the next cycle → two frames separated by at most one idle-high cycle; `overrun=0`.

Source files
------------

// File: rtl/nios_system_char_serializer_if.sv
// -----------------------------------------------------------------------------
// nios_system_char_serializer_if
//
// Purpose : groups the PIO-side request/status signals of the character
//           serializer into one bundle.
// Signals : char_complete_tx  request level from the char_complete_tx PIO
//           char_data[7:0]    character to transmit
//           serial_out        asynchronous serial line (idles high)
//           busy              frame in progress
//           tx_done           one-cycle pulse at the end of the stop bit
//           overrun           sticky: request edge arrived while busy
// Modports: master - software/PIO side (drives request and data)
//           slave  - serializer side (drives line and status)
// -----------------------------------------------------------------------------
interface nios_system_char_serializer_if;
    logic       char_complete_tx;
    logic [7:0] char_data;
    logic       serial_out;
    logic       busy;
    logic       tx_done;
    logic       overrun;

    modport master (
        output char_complete_tx, char_data,
        input  serial_out, busy, tx_done, overrun
    );

    modport slave (
        input  char_complete_tx, char_data,
        output serial_out, busy, tx_done, overrun
    );
endinterface

// File: rtl/nios_system_char_serializer.sv
// -----------------------------------------------------------------------------
// nios_system_char_serializer
//
// Purpose : on each 0->1 edge of char_complete_tx, latches char_data and sends
//           it as a framed asynchronous word (start, 8 data bits LSB first,
//           optional even parity, stop) on serial_out.
// Params  : CLKS_PER_BIT  clock cycles per serial bit (>= 2), default 434
// Ports   : clk      system clock, rising edge
//           reset_n  synchronous active-low reset
//           bus      nios_system_char_serializer_if.slave
//                    (char_complete_tx, char_data in; serial_out, busy,
//                     tx_done, overrun out)
// Config  : `define CHAR_SERIALIZER_PARITY_EN to insert an even-parity bit
//           between the data bits and the stop bit (11-bit frame instead
//           of 10).
// -----------------------------------------------------------------------------
module nios_system_char_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_system_char_serializer_if.slave  bus
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             prev;
    logic             rise;
    logic             bit_end;
`ifdef CHAR_SERIALIZER_PARITY_EN
    logic             parity_bit;
`endif

    assign rise    = bus.char_complete_tx & ~prev;
    assign bit_end = (baud_cnt == CNT_LAST);

    // serial_out, busy and tx_done are registered: each branch assigns the
    // value the line must carry during the *next* cycle.
    // NOTE: sequential state uses non-blocking (<=) so every register sees the
    //       pre-edge values of the others, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            prev           <= 1'b0;
            bus.serial_out <= 1'b1;
            bus.busy       <= 1'b0;
            bus.tx_done    <= 1'b0;
            bus.overrun    <= 1'b0;
`ifdef CHAR_SERIALIZER_PARITY_EN
            parity_bit     <= 1'b0;
`endif
        end else begin
            prev        <= bus.char_complete_tx;
            bus.tx_done <= 1'b0;

            // A request edge outside IDLE is dropped, including the edge that
            // coincides with the end of STOP (state is still STOP then).
            if (rise && state != ST_IDLE) begin
                bus.overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    bus.serial_out <= 1'b1;
                    bus.busy       <= 1'b0;
                    if (rise) begin
                        shift          <= bus.char_data;
                        bus.overrun    <= 1'b0;
                        baud_cnt       <= '0;
                        bus.serial_out <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= ST_START;
`ifdef CHAR_SERIALIZER_PARITY_EN
                        parity_bit     <= ^bus.char_data;
`endif
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        baud_cnt       <= '0;
                        bit_idx        <= '0;
                        bus.serial_out <= shift[0];
                        state          <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef CHAR_SERIALIZER_PARITY_EN
                            bus.serial_out <= parity_bit;
                            state          <= ST_PARITY;
`else
                            bus.serial_out <= 1'b1;
                            state          <= ST_STOP;
`endif
                        end else begin
                            // shift[1] is the bit that lands in shift[0] now.
                            bus.serial_out <= shift[1];
                            bit_idx        <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

`ifdef CHAR_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt       <= '0;
                        bus.serial_out <= 1'b1;
                        state          <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt       <= '0;
                        bus.serial_out <= 1'b1;
                        bus.busy       <= 1'b0;
                        bus.tx_done    <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    baud_cnt       <= '0;
                    bus.serial_out <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
